seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Multi-cycle restoring divider: the subtract-side counterpart of the ALU ripple adder.
//   Computes quotient/remainder of two WIDTH-bit operands, one trial subtraction per clock.
//   Sits beside the adder in the ALU; the core issues Start, stalls on Busy, captures on Done.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>=2)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   Start      in   1      request; sampled only in IDLE
//   Dividend   in   WIDTH  numerator; latched on accepted Start
//   Divisor    in   WIDTH  denominator; latched on accepted Start
//   Busy       out  1      registered; 1 while in RUN
//   Done       out  1      registered; 1-cycle pulse, results valid
//   Quotient   out  WIDTH  result; held until next Done
//   Remainder  out  WIDTH  result; held until next Done
//   DivZero    out  1      divisor was 0; valid with Done, held with results
//   Signed     in   1      (SEQ_DIV_SIGNED_EN only) 1 = two's-complement operands
//   Ovr        out  1      (SEQ_DIV_SIGNED_EN only) signed overflow; held with results
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE; Busy, Done, DivZero, Ovr = 0; Quotient, Remainder = 0;
//     iteration counter 0. Reset mid-operation aborts at once; no Done is produced.
//   FSM: IDLE, RUN, DONE.
//     IDLE: Start=1 and Divisor!=0 -> RUN. Latch operands, clear partial remainder, count=0.
//       Start=1 and Divisor==0 -> DONE. Quotient={WIDTH{1}}, Remainder=Dividend, DivZero=1.
//       Start=0 -> stay in IDLE.
//     RUN: each edge, shift {rem,quo} left 1 and take the next dividend bit from the MSB.
//       Trial: diff = {1'b0,rem} - {1'b0,divisor}, WIDTH+1 bits, borrow = diff MSB.
//       No borrow: rem=diff, quo LSB=1. Borrow: rem unchanged (restore), quo LSB=0.
//       After WIDTH iterations -> DONE. Load Quotient/Remainder, DivZero=0.
//     DONE: Done=1 for exactly one cycle, then IDLE unconditionally. Start is ignored here.
//   Latency: Start sampled at edge k -> Done high after edge k+WIDTH+1 (divide-by-zero: k+1).
//   Throughput: one op per WIDTH+2 cycles with Start held high (re-accepted in IDLE).
//   Start during RUN/DONE is ignored; Dividend/Divisor may change freely after acceptance.
//   Outputs change only on entry to DONE; they hold between operations.
// CONFIGURATION
//   SEQ_DIV_SIGNED_EN defined: Signed and Ovr ports exist. When Signed=1 at Start:
//     - operands are converted to magnitudes and divided unsigned (same latency);
//     - quotient is negated if the operand signs differ (truncate toward zero);
//     - remainder takes the dividend's sign;
//     - MIN/-1 gives Quotient=MIN, Remainder=0, Ovr=1;
//     - divide-by-zero gives the same results as unsigned, with Ovr=0.
//     Ovr is cleared on every completion that does not overflow.
//   SEQ_DIV_SIGNED_EN undefined: unsigned only; Signed/Ovr ports and logic absent.
// TESTING
//   1. Start, 100/7 -> Done exactly 9 cycles after Start edge; Q=14, R=2, DivZero=0.
//   2. 0x2A/0x00 -> Done 1 cycle after Start edge; Q=0xFF, R=0x2A, DivZero=1; Busy never 1.
//   3. 0xFF/0x01 -> Q=0xFF, R=0x00; then 5/9 -> Q=0x00, R=0x05. Results hold while idle.
//   4. Start 200/3, pulse Start with 9/9 during RUN -> ignored, Q=66, R=2.
//      New op with rst_n=0 at RUN cycle 4 -> Busy=0 and outputs 0 immediately, no Done.
//   5. Start held high for 3 ops (50/5, 7/2, 0/3) -> Done every 10 cycles;
//      Q/R = 10/0, 3/1, 0/0.
//   6. [SEQ_DIV_SIGNED_EN] Signed=1: -7/2 -> Q=0xFD, R=0xFF; 7/-2 -> Q=0xFD, R=0x01;
//      -128/-1 -> Q=0x80, R=0x00, Ovr=1; Signed=0, 0xF9/0x02 -> Q=0x7C, R=0x01.

Source files
------------

// File: rtl/seq_divider.sv
// Restoring sequential divider: one trial subtraction per clock, Done one cycle after results load.
// Optional two's-complement mode (Signed/Ovr ports) when SEQ_DIV_SIGNED_EN is defined.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Start,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
`ifdef SEQ_DIV_SIGNED_EN
   input  logic             Signed,
   output logic             Ovr,
`endif
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             DivZero
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
   logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
   logic [WIDTH-1:0] quot_q, quot_d, remd_q, remd_d;

   logic             sgn;
   logic [WIDTH-1:0] a_mag, b_mag, rem_sh, rem_nx, quo_nx;
   logic [WIDTH:0]   diff;

`ifdef SEQ_DIV_SIGNED_EN
   logic ovr_q, ovr_d, ovr_pend_q, ovr_pend_d, ovr_hit;
   assign sgn     = Signed;
   assign ovr_hit = Signed && (Dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (Divisor == '1);
   assign Ovr     = ovr_q;
`else
   assign sgn = 1'b0;
`endif

   // quo_q doubles as the dividend shift register: dividend bits leave at the MSB as quotient bits enter the LSB
   always_comb begin
      a_mag  = (sgn && Dividend[WIDTH-1]) ? -Dividend : Dividend;
      b_mag  = (sgn && Divisor[WIDTH-1])  ? -Divisor  : Divisor;
      rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      diff   = {1'b0, rem_sh} - {1'b0, dvs_q};
      rem_nx = diff[WIDTH] ? rem_sh : diff[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      quot_d    = quot_q;
      remd_d    = remd_q;
      dz_d      = dz_q;
      done_d    = (state_q == DONE);
`ifdef SEQ_DIV_SIGNED_EN
      ovr_d      = ovr_q;
      ovr_pend_d = ovr_pend_q;
`endif
      case (state_q)
         IDLE: begin
            if (Start) begin
               if (Divisor == '0) begin
                  state_d = DONE;
                  quot_d  = '1;
                  remd_d  = Dividend;
                  dz_d    = 1'b1;
`ifdef SEQ_DIV_SIGNED_EN
                  ovr_d   = 1'b0;
`endif
               end else begin
                  state_d   = RUN;
                  quo_d     = a_mag;
                  dvs_d     = b_mag;
                  rem_d     = '0;
                  cnt_d     = '0;
                  neg_quo_d = sgn && (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
                  neg_rem_d = sgn && Dividend[WIDTH-1];
`ifdef SEQ_DIV_SIGNED_EN
                  ovr_pend_d = ovr_hit;
`endif
               end
            end
         end
         RUN: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               quot_d  = neg_quo_q ? -quo_nx : quo_nx;
               remd_d  = neg_rem_q ? -rem_nx : rem_nx;
               dz_d    = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
               ovr_d   = ovr_pend_q;
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
         quot_q    <= '0;
         remd_q    <= '0;
`ifdef SEQ_DIV_SIGNED_EN
         ovr_q      <= 1'b0;
         ovr_pend_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dz_q      <= dz_d;
         quot_q    <= quot_d;
         remd_q    <= remd_d;
`ifdef SEQ_DIV_SIGNED_EN
         ovr_q      <= ovr_d;
         ovr_pend_q <= ovr_pend_d;
`endif
      end
   end

   assign Busy      = busy_q;
   assign Done      = done_q;
   assign Quotient  = quot_q;
   assign Remainder = remd_q;
   assign DivZero   = dz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands against an arithmetic model.
// Signed-mode cases are included when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_divider;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         Start;
   logic [W-1:0] Dividend, Divisor;
   logic         Busy, Done, DivZero;
   logic [W-1:0] Quotient, Remainder;
`ifdef SEQ_DIV_SIGNED_EN
   logic         Signed, Ovr;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Start     (Start),
      .Dividend  (Dividend),
      .Divisor   (Divisor),
`ifdef SEQ_DIV_SIGNED_EN
      .Signed    (Signed),
      .Ovr       (Ovr),
`endif
      .Busy      (Busy),
      .Done      (Done),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .DivZero   (DivZero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One complete operation: model, launch, latency, results, pulse width and hold.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
      logic [W-1:0] eq, er;
      logic         eov, bseen;
      int           sa, sb, lat;
      eov = 1'b0;
      if (b == 0) begin
         eq = '1;
         er = a;
      end else if (sg) begin
         sa  = int'($signed(a));
         sb  = int'($signed(b));
         eq  = W'(sa / sb);
         er  = W'(sa % sb);
         eov = (sa == -128) && (sb == -1);
      end else begin
         eq = a / b;
         er = a % b;
      end
      Dividend = a;
      Divisor  = b;
`ifdef SEQ_DIV_SIGNED_EN
      Signed   = sg;
`endif
      Start = 1'b1;
      @(posedge clk);
      #1;
      Start    = 1'b0;
      Dividend = W'($urandom);
      Divisor  = W'($urandom);
      chk("busy_after_start", Busy, b != 0);
      lat   = 0;
      bseen = Busy;
      while (!Done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         bseen |= Busy;
      end
      chk("latency", lat, (b != 0) ? W + 1 : 1);
      chk("quotient", Quotient, eq);
      chk("remainder", Remainder, er);
      chk("divzero", DivZero, b == 0);
      chk("busy_seen", bseen, b != 0);
`ifdef SEQ_DIV_SIGNED_EN
      chk("ovr", Ovr, eov);
`endif
      @(posedge clk);
      #1;
      chk("done_pulse", Done, 0);
      chk("hold_quotient", Quotient, eq);
   endtask

   initial begin
      logic [W-1:0] bd[3], bv[3], bq[3], br[3];
      int           lat;
      logic         seen;

      rst_n    = 1'b0;
      Start    = 1'b0;
      Dividend = '0;
      Divisor  = '0;
`ifdef SEQ_DIV_SIGNED_EN
      Signed   = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_q", Quotient, 0);
      chk("rst_r", Remainder, 0);
      chk("rst_dz", DivZero, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op(8'd100, 8'd7, 1'b0);
      run_op(8'h2A, 8'h00, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0);
      run_op(8'd5, 8'd9, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      chk("idle_hold_q", Quotient, 8'h00);
      chk("idle_hold_r", Remainder, 8'h05);

      // Start re-pulsed mid-run must not disturb the operation in flight
      Dividend = 8'd200;
      Divisor  = 8'd3;
      Start    = 1'b1;
      @(posedge clk);
      #1;
      Start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      Dividend = 8'd9;
      Divisor  = 8'd9;
      Start    = 1'b1;
      @(posedge clk);
      #1;
      Start = 1'b0;
      lat   = 3;
      while (!Done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("ign_latency", lat, W + 1);
      chk("ign_q", Quotient, 8'd66);
      chk("ign_r", Remainder, 8'd2);
      @(posedge clk);
      #1;

      // Reset during RUN aborts with no Done
      Dividend = 8'd100;
      Divisor  = 8'd7;
      Start    = 1'b1;
      @(posedge clk);
      #1;
      Start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", Busy, 0);
      chk("abort_done", Done, 0);
      chk("abort_q", Quotient, 0);
      chk("abort_r", Remainder, 0);
      chk("abort_dz", DivZero, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (15) begin
         @(posedge clk);
         #1;
         seen |= Done;
      end
      chk("abort_no_done", seen, 0);

      // Start held high: back-to-back operations, one Done every W+2 cycles
      bd = '{8'd50, 8'd7, 8'd0};
      bv = '{8'd5, 8'd2, 8'd3};
      bq = '{8'd10, 8'd3, 8'd0};
      br = '{8'd0, 8'd1, 8'd0};
      Dividend = bd[0];
      Divisor  = bv[0];
      Start    = 1'b1;
      @(posedge clk);
      #1;
      Dividend = bd[1];
      Divisor  = bv[1];
      for (int i = 0; i < 3; i++) begin
         lat = 0;
         while (!Done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
         end
         chk("b2b_latency", lat, W + 1);
         chk("b2b_q", Quotient, bq[i]);
         chk("b2b_r", Remainder, br[i]);
         if (i < 2) begin
            @(posedge clk);
            #1;
            chk("b2b_reaccept", Busy, 1);
            if (i == 0) begin
               Dividend = bd[2];
               Divisor  = bv[2];
            end
         end else begin
            Start = 1'b0;
         end
      end
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_idle", Busy, 0);

      for (int n = 0; n < 40; n++) begin
         run_op(W'($urandom), ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom), 1'b0);
      end

`ifdef SEQ_DIV_SIGNED_EN
      run_op(8'hF9, 8'h02, 1'b1);
      run_op(8'h07, 8'hFE, 1'b1);
      run_op(8'h80, 8'hFF, 1'b1);
      run_op(8'hF9, 8'h02, 1'b0);
      run_op(8'h85, 8'h00, 1'b1);
      for (int n = 0; n < 30; n++) begin
         run_op(W'($urandom), ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom),
                1'($urandom_range(0, 1)));
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
